// File: rtl/rv32i_ctrl_fsm_if.sv
// Memory request channel between the RV32I control sequencer and the shared
// instruction/data memory port.
interface rv32i_ctrl_fsm_if;
    // mem_req/mem_we/mem_addr_sel/mem_size are held stable while mem_req is high
    // until mem_ready is sampled high on a rising edge. That edge completes the
    // transfer. mem_ready has no meaning while mem_req is low.
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [1:0] mem_size;
    logic       mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        output mem_size,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        input  mem_size,
        output mem_ready
    );
endinterface

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core. Walks FETCH/DECODE/EXEC/MEM/WB
// with one instruction in flight, and traps on illegal opcodes or stalled memory.
module rv32i_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 br_taken,
    rv32i_ctrl_fsm_if.master     mem,
    output logic                 ir_we,
    output logic                 mdr_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // The watchdog only ever needs to hold values up to MEM_TIMEOUT-1.
    localparam int               WD_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    state_t          st, st_d;
    logic [WD_W-1:0] wd;
    logic            mem_req_q, mem_we_q, mem_addr_sel_q;
    logic [1:0]      mem_size_q;
    logic            pc_we_q, rf_we_q;
    logic [1:0]      pc_sel_q, wb_sel_q;
    logic            is_load, is_store, is_op, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic            legal, mem_phase, wd_expire, retire;
    logic            unused_funct3;

    assign unused_funct3 = funct3[2];

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_op     = (opcode == OPC_OP);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign legal     = is_load | is_store | is_op | is_branch | is_jal | is_jalr |
                       is_lui | is_auipc | (opcode == OPC_OPIMM);

    always_comb begin
        st_d      = st;
        mem_phase = (st == S_FETCH) || (st == S_MEM);
        // A completing transfer in the limit cycle beats the watchdog.
        wd_expire = mem_phase && !mem.mem_ready && (wd == WD_LAST);
        retire    = 1'b0;
        case (st)
            S_IDLE:   st_d = S_FETCH;
            S_FETCH:  if (mem.mem_ready) st_d = S_DECODE;
                      else if (wd_expire) st_d = S_TRAP;
            S_DECODE: st_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_load || is_store) begin
                    st_d = S_MEM;
                end else if (is_branch || is_jal || is_jalr) begin
                    st_d   = S_FETCH;
                    retire = 1'b1;
                end else begin
                    st_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    st_d   = is_load ? S_WB : S_FETCH;
                    retire = is_store;
                end else if (wd_expire) begin
                    st_d = S_TRAP;
                end
            end
            S_WB: begin
                st_d   = S_FETCH;
                retire = 1'b1;
            end
            S_TRAP:   st_d = S_TRAP;
            default:  st_d = S_TRAP;
        endcase
    end

    // Moore outputs are registered from the next state, so they are valid for the
    // whole cycle the state is occupied and stay frozen while a request stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= S_IDLE;
            wd             <= '0;
            instret        <= '0;
            trap           <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            mem_size_q     <= 2'b00;
            pc_we_q        <= 1'b0;
            pc_sel_q       <= 2'b00;
            rf_we_q        <= 1'b0;
            wb_sel_q       <= 2'b00;
            alu_a_sel      <= 2'b00;
            alu_b_sel      <= 1'b0;
        end else begin
            st <= st_d;
            if ((st_d == S_FETCH || st_d == S_MEM) && st_d != st) begin
                wd <= '0;
            end else if (mem_phase && !mem.mem_ready) begin
                wd <= wd + 1'b1;
            end
            if (retire) instret <= instret + 1'b1;
            if (st_d == S_TRAP) trap <= 1'b1;

            mem_req_q      <= (st_d == S_FETCH) || (st_d == S_MEM);
            mem_addr_sel_q <= (st_d == S_MEM);
            mem_we_q       <= (st_d == S_MEM) && is_store;
            mem_size_q     <= (st_d == S_MEM) ? funct3[1:0] : 2'b00;
            rf_we_q        <= (st_d == S_WB) || ((st_d == S_EXEC) && (is_jal || is_jalr));
            pc_we_q        <= (st_d == S_WB) ||
                              ((st_d == S_EXEC) && (is_branch || is_jal || is_jalr));
            if (st_d == S_WB)                    wb_sel_q <= is_load ? 2'b01 : 2'b00;
            else if (st_d == S_EXEC && (is_jal || is_jalr)) wb_sel_q <= 2'b10;
            else                                 wb_sel_q <= 2'b00;
            if (st_d == S_EXEC && is_jal)        pc_sel_q <= 2'b01;
            else if (st_d == S_EXEC && is_jalr)  pc_sel_q <= 2'b10;
            else                                 pc_sel_q <= 2'b00;

            if (st_d == S_EXEC) begin
                if (is_op) begin
                    alu_a_sel <= 2'b00;
                    alu_b_sel <= 1'b0;
                end else if (is_lui) begin
                    alu_a_sel <= 2'b10;
                    alu_b_sel <= 1'b1;
                end else if (is_auipc || is_branch || is_jal) begin
                    alu_a_sel <= 2'b01;
                    alu_b_sel <= 1'b1;
                end else begin
                    alu_a_sel <= 2'b00;
                    alu_b_sel <= 1'b1;
                end
            end
        end
    end

    assign mem.mem_req      = mem_req_q;
    assign mem.mem_we       = mem_we_q;
    assign mem.mem_addr_sel = mem_addr_sel_q;
    assign mem.mem_size     = mem_size_q;

    // Strobes that depend on this cycle's handshake or branch outcome.
    assign ir_we  = (st == S_FETCH) && mem.mem_ready;
    assign mdr_we = (st == S_MEM) && is_load && mem.mem_ready;
    assign pc_we  = pc_we_q || ((st == S_MEM) && is_store && mem.mem_ready);
    assign pc_sel = ((st == S_EXEC) && is_branch) ? {1'b0, br_taken} : pc_sel_q;
    assign rf_we  = rf_we_q;
    assign wb_sel = wb_sel_q;
    assign state  = st;
endmodule
